lcd_stream_controller: RTL and testbench

Parametrised RGB-parallel LCD controller. It generates DE-mode and HSYNC/VSYNC panel timing and drains a valid/ready pixel stream into the active window. It supports single-shot or continuous frames and flags underflow. It sits between the pixel pipeline (framebuffer reader / renderer) and the panel pins, replacing the fixed-colour, single-frame, DE-only controller.

---
 rtl/lcd_pkg.sv | 33 +++
 rtl/lcd_phase_counter.sv | 58 +++++
 rtl/lcd_stream_controller.sv | 187 ++++++++++++++++++
 tb/tb_lcd_stream_controller.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared types and default timing for the RGB-parallel LCD stream controller.
// Phase encoding is common to the frame FSM and both phase counters.
package lcd_pkg;

  typedef enum logic [1:0] {
    PH_IDLE = 2'd0,
    PH_BP   = 2'd1,
    PH_ACT  = 2'd2,
    PH_FP   = 2'd3
  } phase_e;

  // 800x480 panel defaults
  localparam int unsigned DEF_H_BP     = 10;
  localparam int unsigned DEF_H_ACTIVE = 800;
  localparam int unsigned DEF_H_FP     = 40;
  localparam int unsigned DEF_H_SYNC   = 4;
  localparam int unsigned DEF_V_BP     = 10;
  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_FP     = 10;
  localparam int unsigned DEF_V_SYNC   = 2;
  localparam int unsigned DEF_CW       = 8;

  // HSYNC/VSYNC are active-low on this panel family
  localparam logic SYNC_ACTIVE = 1'b0;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/lcd_phase_counter.sv
// One timing axis: cycles BP -> ACT -> FP -> BP, counting slots within each segment.
// Used for horizontal (advance every clk) and vertical (advance on line wrap).
module lcd_phase_counter
  import lcd_pkg::*;
#(
  parameter int unsigned BP    = 10,
  parameter int unsigned ACT   = 800,
  parameter int unsigned FP    = 40,
  parameter int unsigned SYNC  = 4,
  parameter int unsigned CNT_W = $clog2(max3(BP, ACT, FP)) + 1
) (
  input  logic             clk,
  input  logic             aresetn,
  input  logic             clear,
  input  logic             advance,
  output phase_e           phase,
  output logic [CNT_W-1:0] count,
  output logic             wrap,
  output logic             sync_n
);

  logic [CNT_W-1:0] last;
  logic             seg_end;

  always_comb begin
    last = CNT_W'(BP - 1);
    case (phase)
      PH_ACT:  last = CNT_W'(ACT - 1);
      PH_FP:   last = CNT_W'(FP - 1);
      default: last = CNT_W'(BP - 1);
    endcase
  end

  assign seg_end = (count == last);

  always_ff @(posedge clk) begin
    if (!aresetn || clear) begin
      phase <= PH_BP;
      count <= '0;
    end else if (advance) begin
      if (seg_end) begin
        count <= '0;
        case (phase)
          PH_BP:   phase <= PH_ACT;
          PH_ACT:  phase <= PH_FP;
          default: phase <= PH_BP;
        endcase
      end else begin
        count <= count + CNT_W'(1);
      end
    end
  end

  // wrap marks the final slot of the whole BP+ACT+FP period
  assign wrap   = advance && seg_end && (phase == PH_FP);
  assign sync_n = ((phase == PH_BP) && (count < CNT_W'(SYNC))) ? SYNC_ACTIVE : ~SYNC_ACTIVE;

endmodule

// File: rtl/lcd_stream_controller.sv
// DE + HSYNC/VSYNC LCD timing generator that drains a valid/ready pixel stream
// into the active window, single-shot or continuous, with sticky underflow flag.
module lcd_stream_controller
  import lcd_pkg::*;
#(
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned CW       = DEF_CW,
  parameter logic [3*CW-1:0] UNDERFLOW_RGB = (3*CW)'(24'hFF00FF),
  localparam int unsigned X_W  = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1,
  localparam int unsigned Y_W  = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1,
  localparam int unsigned H_CW = $clog2(max3(H_BP, H_ACTIVE, H_FP)) + 1,
  localparam int unsigned V_CW = $clog2(max3(V_BP, V_ACTIVE, V_FP)) + 1
) (
  input  logic            clk,
  input  logic            aresetn,
  input  logic            i_start,
  input  logic            i_continuous,
  input  logic            i_stop,
  input  logic            s_valid,
  input  logic [3*CW-1:0] s_data,
  output logic            s_ready,
  output logic            o_clk,
  output logic            o_data_en,
  output logic            o_hsync,
  output logic            o_vsync,
  output logic [CW-1:0]   o_red,
  output logic [CW-1:0]   o_green,
  output logic [CW-1:0]   o_blue,
  output logic [X_W-1:0]  o_x,
  output logic [Y_W-1:0]  o_y,
  output logic            o_frame_start,
  output logic            o_busy,
  output logic            o_underflow
);

  phase_e            state, state_nxt;
  logic              frame_begin;
  logic              busy;
  logic              mode;
  logic              stop_req;
  logic              stop_now;

  phase_e            h_phase, v_phase;
  logic [H_CW-1:0]   h_count;
  logic [V_CW-1:0]   v_count;
  logic              h_wrap, v_wrap;
  logic              h_sync_n, v_sync_n;
  logic              active;
  logic              first_slot;

  assign busy = (state != PH_IDLE);

  // Counters sit at BP/0 while idle, so the first slot is ready on the start edge
  lcd_phase_counter #(
    .BP   (H_BP),
    .ACT  (H_ACTIVE),
    .FP   (H_FP),
    .SYNC (H_SYNC),
    .CNT_W(H_CW)
  ) u_hcnt (
    .clk    (clk),
    .aresetn(aresetn),
    .clear  (!busy),
    .advance(busy),
    .phase  (h_phase),
    .count  (h_count),
    .wrap   (h_wrap),
    .sync_n (h_sync_n)
  );

  lcd_phase_counter #(
    .BP   (V_BP),
    .ACT  (V_ACTIVE),
    .FP   (V_FP),
    .SYNC (V_SYNC),
    .CNT_W(V_CW)
  ) u_vcnt (
    .clk    (clk),
    .aresetn(aresetn),
    .clear  (!busy),
    .advance(busy && h_wrap),
    .phase  (v_phase),
    .count  (v_count),
    .wrap   (v_wrap),
    .sync_n (v_sync_n)
  );

  // A stop raised in the very last slot still prevents the restart
  assign stop_now = stop_req || i_stop;

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      state <= PH_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    frame_begin = 1'b0;
    case (state)
      PH_IDLE: begin
        if (i_start) begin
          state_nxt   = PH_BP;
          frame_begin = 1'b1;
        end
      end
      PH_BP: begin
        if (h_wrap && (v_count == V_CW'(V_BP - 1))) state_nxt = PH_ACT;
      end
      PH_ACT: begin
        if (h_wrap && (v_count == V_CW'(V_ACTIVE - 1))) state_nxt = PH_FP;
      end
      PH_FP: begin
        if (v_wrap) begin
          if (mode && !stop_now) begin
            state_nxt   = PH_BP;
            frame_begin = 1'b1;
          end else begin
            state_nxt = PH_IDLE;
          end
        end
      end
      default: state_nxt = PH_IDLE;
    endcase
  end

  // Start with stop together loads a pending stop, giving exactly one frame
  always_ff @(posedge clk) begin
    if (!aresetn) begin
      mode     <= 1'b0;
      stop_req <= 1'b0;
    end else if (frame_begin) begin
      mode     <= i_continuous;
      stop_req <= i_stop;
    end else if (busy && i_stop) begin
      stop_req <= 1'b1;
    end
  end

  assign active     = (state == PH_ACT) && (h_phase == PH_ACT);
  assign first_slot = (state == PH_BP) && (v_phase == PH_BP) && (v_count == '0) &&
                      (h_phase == PH_BP) && (h_count == '0);

  assign s_ready = active;
  assign o_busy  = busy;
  assign o_clk   = ~clk;

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      o_data_en                  <= 1'b0;
      o_hsync                    <= ~SYNC_ACTIVE;
      o_vsync                    <= ~SYNC_ACTIVE;
      {o_red, o_green, o_blue}   <= '0;
      o_x                        <= '0;
      o_y                        <= '0;
      o_frame_start              <= 1'b0;
      o_underflow                <= 1'b0;
    end else begin
      o_data_en     <= active;
      o_hsync       <= busy ? h_sync_n : ~SYNC_ACTIVE;
      o_vsync       <= busy ? v_sync_n : ~SYNC_ACTIVE;
      o_x           <= active ? X_W'(h_count) : '0;
      o_y           <= active ? Y_W'(v_count) : '0;
      o_frame_start <= busy && first_slot;
      if (active) begin
        {o_red, o_green, o_blue} <= s_valid ? s_data : UNDERFLOW_RGB;
      end else begin
        {o_red, o_green, o_blue} <= '0;
      end
      if (frame_begin) begin
        o_underflow <= 1'b0;
      end else if (active && !s_valid) begin
        o_underflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_lcd_stream_controller.sv
// Directed bench for lcd_stream_controller on a 9x4-slot miniature panel.
module tb_lcd_stream_controller;

  localparam int HBP = 2, HACT = 4, HFP = 3, HS = 1;
  localparam int VBP = 1, VACT = 2, VFP = 1, VS = 1;
  localparam int LINE  = HBP + HACT + HFP;
  localparam int NSLOT = LINE * (VBP + VACT + VFP);
  localparam logic [23:0] UF = 24'hFF00FF;

  logic        clk = 1'b0;
  logic        aresetn, i_start, i_continuous, i_stop, s_valid;
  logic [23:0] s_data;
  logic        s_ready, o_clk, o_data_en, o_hsync, o_vsync;
  logic [7:0]  o_red, o_green, o_blue;
  logic [1:0]  o_x;
  logic [0:0]  o_y;
  logic        o_frame_start, o_busy, o_underflow;

  always #5 clk = ~clk;

  lcd_stream_controller #(
    .H_BP(HBP), .H_ACTIVE(HACT), .H_FP(HFP), .H_SYNC(HS),
    .V_BP(VBP), .V_ACTIVE(VACT), .V_FP(VFP), .V_SYNC(VS),
    .CW(8), .UNDERFLOW_RGB(UF)
  ) dut (
    .clk(clk), .aresetn(aresetn), .i_start(i_start), .i_continuous(i_continuous),
    .i_stop(i_stop), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .o_clk(o_clk), .o_data_en(o_data_en), .o_hsync(o_hsync), .o_vsync(o_vsync),
    .o_red(o_red), .o_green(o_green), .o_blue(o_blue), .o_x(o_x), .o_y(o_y),
    .o_frame_start(o_frame_start), .o_busy(o_busy), .o_underflow(o_underflow)
  );

  typedef struct {
    logic de;
    logic hs;
    logic vs;
    logic fs;
    int   x;
    int   y;
  } vec_t;

  vec_t        tbl [NSLOT];
  int          checks = 0;
  int          errors = 0;
  int unsigned pix = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance one clock; a pixel offered with s_ready high is consumed on that edge
  task automatic cyc();
    logic take;
    take = s_ready && s_valid;
    @(negedge clk);
    if (take) pix = pix + 1;
    s_data = 24'(pix);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_de"},    32'(o_data_en), 32'd0);
    chk({tag, "_hs"},    32'(o_hsync), 32'd1);
    chk({tag, "_vs"},    32'(o_vsync), 32'd1);
    chk({tag, "_rgb"},   32'({o_red, o_green, o_blue}), 32'd0);
    chk({tag, "_x"},     32'(o_x), 32'd0);
    chk({tag, "_y"},     32'(o_y), 32'd0);
    chk({tag, "_fs"},    32'(o_frame_start), 32'd0);
    chk({tag, "_busy"},  32'(o_busy), 32'd0);
    chk({tag, "_uf"},    32'(o_underflow), 32'd0);
    chk({tag, "_ready"}, 32'(s_ready), 32'd0);
  endtask

  // One single-shot frame checked slot by slot against tbl
  task automatic run_single(input int uf_slot, input int poke_slot);
    int unsigned exp_pix;
    int          de_cnt, hs_low, vs_low, fs_cnt, overlap;
    logic        uf_flag;
    exp_pix = pix; de_cnt = 0; hs_low = 0; vs_low = 0; fs_cnt = 0; overlap = 0;
    uf_flag = 1'b0;
    i_continuous = 1'b0; i_stop = 1'b0; s_valid = 1'b1; i_start = 1'b1;
    cyc();
    i_start = 1'b0;
    chk("start_busy", 32'(o_busy), 32'd1);
    chk("start_uf_clear", 32'(o_underflow), 32'd0);
    for (int s = 0; s < NSLOT; s++) begin
      s_valid = (s != uf_slot);
      i_start = (s == poke_slot);
      cyc();
      if (s == uf_slot) uf_flag = 1'b1;
      chk("de", 32'(o_data_en), 32'(tbl[s].de));
      chk("hsync", 32'(o_hsync), 32'(tbl[s].hs));
      chk("vsync", 32'(o_vsync), 32'(tbl[s].vs));
      chk("frame_start", 32'(o_frame_start), 32'(tbl[s].fs));
      chk("x", 32'(o_x), 32'(tbl[s].x));
      chk("y", 32'(o_y), 32'(tbl[s].y));
      chk("underflow", 32'(o_underflow), 32'(uf_flag));
      if (!tbl[s].de)
        chk("rgb_blank", 32'({o_red, o_green, o_blue}), 32'd0);
      else if (s == uf_slot)
        chk("rgb_uf", 32'({o_red, o_green, o_blue}), 32'(UF));
      else begin
        chk("rgb_pix", 32'({o_red, o_green, o_blue}), 32'(exp_pix[23:0]));
        exp_pix = exp_pix + 1;
      end
      if (o_data_en) de_cnt++;
      if (!o_hsync) hs_low++;
      if (!o_vsync) vs_low++;
      if (o_frame_start) fs_cnt++;
      if (o_data_en && (!o_hsync || !o_vsync)) overlap++;
    end
    i_start = 1'b0; s_valid = 1'b1;
    chk("end_busy", 32'(o_busy), 32'd0);
    chk("de_count", 32'(de_cnt), 32'(HACT * VACT));
    chk("hsync_low_count", 32'(hs_low), 32'(HS * (VBP + VACT + VFP)));
    chk("vsync_low_count", 32'(vs_low), 32'(VS * LINE));
    chk("fs_count", 32'(fs_cnt), 32'd1);
    chk("de_sync_overlap", 32'(overlap), 32'd0);
    chk("end_uf_sticky", 32'(o_underflow), 32'(uf_flag));
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("idle_fs", 32'(o_frame_start), 32'd0);
      chk("idle_de", 32'(o_data_en), 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int t0, t1, fs_cnt;

    for (int s = 0; s < NSLOT; s++) begin
      int ln, px;
      ln = s / LINE;
      px = s % LINE;
      tbl[s].de = (ln >= VBP) && (ln < VBP + VACT) && (px >= HBP) && (px < HBP + HACT);
      tbl[s].hs = !(px < HS);
      tbl[s].vs = !(ln < VS);
      tbl[s].fs = (s == 0);
      tbl[s].x  = tbl[s].de ? px - HBP : 0;
      tbl[s].y  = tbl[s].de ? ln - VBP : 0;
    end

    aresetn = 1'b0; i_start = 1'b0; i_continuous = 1'b0; i_stop = 1'b0;
    s_valid = 1'b1; s_data = '0;
    repeat (3) cyc();
    check_reset("reset");
    aresetn = 1'b1;
    cyc();

    // single shot, with a stray i_start while busy at slot 10
    run_single(-1, 10);

    // underflow on active slot 5 (line 2, x=1), then next frame clears it
    run_single(2 * LINE + HBP + 1, -1);
    run_single(-1, -1);

    // continuous with stop pulsed inside frame 2
    t0 = -1; t1 = -1; fs_cnt = 0;
    i_continuous = 1'b1; i_start = 1'b1;
    cyc();
    i_start = 1'b0;
    for (int k = 0; k < 150; k++) begin
      i_stop = (fs_cnt == 2) && (k == t1 + 10);
      cyc();
      i_stop = 1'b0;
      if (o_frame_start) begin
        if (fs_cnt == 0) t0 = k;
        if (fs_cnt == 1) t1 = k;
        fs_cnt++;
      end
    end
    chk("cont_frames", 32'(fs_cnt), 32'd2);
    chk("cont_period", 32'(t1 - t0), 32'(NSLOT));
    chk("cont_idle", 32'(o_busy), 32'd0);

    // reset mid-VACT
    i_continuous = 1'b0; i_start = 1'b1;
    cyc();
    i_start = 1'b0;
    repeat (LINE + HBP + 2) cyc();
    chk("pre_rst_busy", 32'(o_busy), 32'd1);
    aresetn = 1'b0;
    cyc();
    aresetn = 1'b1;
    check_reset("midrst");
    repeat (5) cyc();
    chk("midrst_idle", 32'(o_busy), 32'd0);
    run_single(-1, -1);

    // start and stop together in continuous mode -> one frame
    fs_cnt = 0;
    i_continuous = 1'b1; i_stop = 1'b1; i_start = 1'b1;
    cyc();
    i_start = 1'b0; i_stop = 1'b0;
    for (int k = 0; k < 100; k++) begin
      cyc();
      if (o_frame_start) fs_cnt++;
    end
    chk("startstop_frames", 32'(fs_cnt), 32'd1);
    chk("startstop_idle", 32'(o_busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
